conv2_maxpool: RTL
==================

# conv2_maxpool

2x2, stride-2 max-pooling stage directly downstream of the second convolution layer. Consumes the 9-channel raster stream of 8x8 pointwise-convolution results (one pixel per channel per valid cycle) and emits a 9-channel 4x4 pooled stream. It uses a half-row line buffer per channel, so it needs no frame storage. Its output feeds the flatten/fully-connected stage.

## Interface
- WIDTH, 8: input feature-map columns; must be even.
- HEIGHT, 8: input feature-map rows; must be even.
- DATA_BITS, 14: signed sample width, for both input and output.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- valid_in  in  1  qualifies all conv*_in for this cycle.
- conv1_in … conv9_in  in  DATA_BITS each, signed  one sample per channel, raster order (row-major, column fastest).
- max1_out … max9_out  out  DATA_BITS each, signed  pooled result per channel.
- valid_out  out  1  qualifies max*_out; one-cycle pulse per pooled pixel.
- frame_done  out  1  one-cycle pulse coincident with valid_out of the last pooled pixel (row HEIGHT/2-1, col WIDTH/2-1).

## Operation
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on valid_in.
  - col wraps to 0 after WIDTH-1, and row then increments.
  - row wraps to 0 after HEIGHT-1, so frames run back-to-back with no gap.
- Per channel, each valid sample is handled by column parity:
  - Even col: the sample is latched in hold_reg.
  - Odd col: hmax = signed max(hold_reg, sample).
- hmax is routed by row parity:
  - Even row: hmax is written to line_buf[col>>1] (depth WIDTH/2).
  - Odd row: the result is signed max(line_buf[col>>1], hmax), registered to max*_out, with valid_out asserted.
- Comparisons are signed, DATA_BITS wide. On equality the earlier operand is selected; the value is the same either way.
- No width growth: output width equals input width.
- Gaps in valid_in are allowed anywhere, including inside a 2x2 window.
  - State is held during gaps.
  - No output is produced without a qualifying input.
- No backpressure: the downstream stage must accept every valid_out.
- Control state: the counters alone determine phase; there is no separate FSM.
  - Phases are STORE_H (even col), CMP_H_WR (odd col, even row) and CMP_H_V_OUT (odd col, odd row).

## Timing
- Reset values: valid_out=0, frame_done=0, all max*_out=0, col=0, row=0, hold_reg=0, line_buf contents=0.
- Latency: valid_out rises exactly 1 cycle after the valid_in of the bottom-right sample of each 2x2 window.
- Throughput, at continuous valid_in: one output per 2 input cycles on odd rows, none on even rows. The result is WIDTH*HEIGHT/4 outputs per WIDTH*HEIGHT inputs.
- max*_out holds its last value while valid_out=0.
- Reset asserted mid-frame: all state clears immediately. The first valid_in after release is treated as pixel (0,0), and no partial-window output is emitted.
- Frame boundary: the valid_in of pixel (HEIGHT-1, WIDTH-1) produces valid_out and frame_done on the next cycle. A valid_in on that same next cycle is accepted as pixel (0,0) of the next frame.

## Configuration
- CONV2_MAXPOOL_RELU_EN
  - Defined: each pooled result is clamped to 0 when negative before registering, i.e. ReLU fused after the pool (equivalent to pool-after-ReLU for max).
  - Undefined: the raw signed max is output, and negative values pass through.
  - Affects only the output datapath. Latency and handshake are identical in both cases.

## Structure
- Shared package (cnn_pkg) holds:
  - C2_OUT_W=8, C2_OUT_H=8, C2_CH=9, C2_DATA_BITS=14.
  - A signed sample typedef for DATA_BITS.
  - A signed_max function.
- One sub-module, maxpool2_lane: a single-channel hold_reg, line_buf and compare path, instantiated 9 times.
  - col parity, row parity and col>>1 come from a shared counter block in the top level.
  - valid_out and frame_done are generated once in the top level.

## Test plan
- Single channel, ramp stimulus: conv1_in = row*8+col for 64 continuous valid cycles. Expect max1_out = 9,11,13,15,25,…,63 (16 outputs), each 1 cycle after its odd/odd input, and frame_done with the value 63.
- Signed values: window {-5,-3,-8,-100} gives -3 (RELU_EN undefined) or 0 (RELU_EN defined). Window {-8192,8191,0,0} gives 8191.
- Random gaps: valid_in toggles pseudo-randomly over 2 frames with random data, and outputs match a golden 2x2 max model. Expect exactly 32 valid_out and 2 frame_done pulses.
- Back-to-back frames: 128 continuous valid cycles give the second frame's outputs correct, with no corruption from line_buf reuse.
- Reset mid-frame: assert rst_n=0 after 37 samples. Expect valid_out=0 and outputs=0 immediately. A fresh 64-sample frame then gives 16 correct outputs.
- All 9 channels with distinct data (channel k = k*100 + pixel index): each max k_out equals its own channel's pooled value, with no cross-channel leakage.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline: conv2 geometry, the signed sample type,
// the max-pool phase encoding and a signed max helper.
package cnn_pkg;

    localparam int unsigned C2_OUT_W     = 8;
    localparam int unsigned C2_OUT_H     = 8;
    localparam int unsigned C2_CH        = 9;
    localparam int unsigned C2_DATA_BITS = 14;

    typedef logic signed [C2_DATA_BITS-1:0] c2_sample_t;

    typedef enum logic [1:0] {
        PhStoreH,
        PhCmpHWr,
        PhCmpHVOut
    } pool_phase_t;

    // Ties keep the first operand; the value is identical either way.
    function automatic c2_sample_t signed_max(input c2_sample_t a, input c2_sample_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/maxpool2_lane.sv
// Single-channel 2x2/stride-2 max-pool datapath: horizontal hold register, half-row line
// buffer and vertical compare. Optional ReLU on the result under CONV2_MAXPOOL_RELU_EN.
module maxpool2_lane
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH     = C2_OUT_W / 2,
    parameter int unsigned IDX_BITS  = 2,
    parameter int unsigned DATA_BITS = C2_DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic                        col_odd,
    input  logic                        row_odd,
    input  logic [IDX_BITS-1:0]         idx,
    input  logic signed [DATA_BITS-1:0] sample,
    output logic signed [DATA_BITS-1:0] max_out
);

    pool_phase_t                 phase;
    logic signed [DATA_BITS-1:0] hold_reg;
    logic signed [DATA_BITS-1:0] line_buf [DEPTH];
    logic signed [DATA_BITS-1:0] hmax;
    logic signed [DATA_BITS-1:0] vmax;
    logic signed [DATA_BITS-1:0] result;

    always_comb begin
        phase = PhStoreH;
        if (col_odd) begin
            phase = row_odd ? PhCmpHVOut : PhCmpHWr;
        end
    end

    always_comb begin
        hmax   = signed_max(hold_reg, sample);
        vmax   = signed_max(line_buf[idx], hmax);
        result = vmax;
`ifdef CONV2_MAXPOOL_RELU_EN
        if (vmax < 0) begin
            result = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
            max_out  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                line_buf[i] <= '0;
            end
        end else if (valid_in) begin
            unique case (phase)
                PhStoreH:   hold_reg      <= sample;
                PhCmpHWr:   line_buf[idx] <= hmax;
                PhCmpHVOut: max_out       <= result;
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/conv2_maxpool.sv
// 9-channel 2x2/stride-2 max-pool after conv2. Shared raster counters drive nine lanes.
// Build macro: CONV2_MAXPOOL_RELU_EN clamps negative pooled results to zero.
module conv2_maxpool
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH     = C2_OUT_W,
    parameter int unsigned HEIGHT    = C2_OUT_H,
    parameter int unsigned DATA_BITS = C2_DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] conv1_in,
    input  logic signed [DATA_BITS-1:0] conv2_in,
    input  logic signed [DATA_BITS-1:0] conv3_in,
    input  logic signed [DATA_BITS-1:0] conv4_in,
    input  logic signed [DATA_BITS-1:0] conv5_in,
    input  logic signed [DATA_BITS-1:0] conv6_in,
    input  logic signed [DATA_BITS-1:0] conv7_in,
    input  logic signed [DATA_BITS-1:0] conv8_in,
    input  logic signed [DATA_BITS-1:0] conv9_in,
    output logic signed [DATA_BITS-1:0] max1_out,
    output logic signed [DATA_BITS-1:0] max2_out,
    output logic signed [DATA_BITS-1:0] max3_out,
    output logic signed [DATA_BITS-1:0] max4_out,
    output logic signed [DATA_BITS-1:0] max5_out,
    output logic signed [DATA_BITS-1:0] max6_out,
    output logic signed [DATA_BITS-1:0] max7_out,
    output logic signed [DATA_BITS-1:0] max8_out,
    output logic signed [DATA_BITS-1:0] max9_out,
    output logic                        valid_out,
    output logic                        frame_done
);

    localparam int unsigned COL_BITS = $clog2(WIDTH);
    localparam int unsigned ROW_BITS = $clog2(HEIGHT);
    localparam int unsigned IDX_BITS = COL_BITS - 1;
    localparam int unsigned DEPTH    = WIDTH / 2;

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                col_last;
    logic                row_last;

    logic signed [DATA_BITS-1:0] conv_in [C2_CH];
    logic signed [DATA_BITS-1:0] lane_max [C2_CH];

    assign col_last = (col == COL_BITS'(WIDTH - 1));
    assign row_last = (row == ROW_BITS'(HEIGHT - 1));

    // Counters alone define the phase; frames run back-to-back with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in & col[0] & row[0];
            frame_done <= valid_in & col_last & row_last;
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_BITS'(1);
                end else begin
                    col <= col + COL_BITS'(1);
                end
            end
        end
    end

    assign conv_in[0] = conv1_in;
    assign conv_in[1] = conv2_in;
    assign conv_in[2] = conv3_in;
    assign conv_in[3] = conv4_in;
    assign conv_in[4] = conv5_in;
    assign conv_in[5] = conv6_in;
    assign conv_in[6] = conv7_in;
    assign conv_in[7] = conv8_in;
    assign conv_in[8] = conv9_in;

    for (genvar k = 0; k < int'(C2_CH); k++) begin : g_lane
        maxpool2_lane #(
            .DEPTH     (DEPTH),
            .IDX_BITS  (IDX_BITS),
            .DATA_BITS (DATA_BITS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (valid_in),
            .col_odd  (col[0]),
            .row_odd  (row[0]),
            .idx      (col[COL_BITS-1:1]),
            .sample   (conv_in[k]),
            .max_out  (lane_max[k])
        );
    end

    assign max1_out = lane_max[0];
    assign max2_out = lane_max[1];
    assign max3_out = lane_max[2];
    assign max4_out = lane_max[3];
    assign max5_out = lane_max[4];
    assign max6_out = lane_max[5];
    assign max7_out = lane_max[6];
    assign max8_out = lane_max[7];
    assign max9_out = lane_max[8];

endmodule
